gcd_controller: RTL and testbench

//   Control FSM for the 16-bit subtractive GCD datapath (GCD_datapath); sits directly upstream of it.

---
 rtl/gcd_controller.sv | 125 ++++++++++++
 tb/tb_gcd_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath: operand-load handshake,
// subtraction sequencing from gt/lt/eq, done/error reporting with an iteration timeout.
module gcd_controller #(
  parameter int          ITER_W   = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ITER_W-1:0] LP_MAX = ITER_W'(MAX_ITER);

  state_t            r_state;
  state_t            w_next;
  logic [ITER_W-1:0] r_iter;
  logic              w_iter_clr;
  logic              w_iter_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (w_iter_clr)
        r_iter <= '0;
      else if (w_iter_inc)
        r_iter <= r_iter + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_iter_clr = 1'b0;
    w_iter_inc = 1'b0;
    in_ready   = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel_in     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          ldA    = 1'b1;
          sel_in = 1'b1;
          w_next = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          ldB        = 1'b1;
          sel_in     = 1'b1;
          w_iter_clr = 1'b1;
          w_next     = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        // Equality wins over the timeout so a run converging on the last allowed step still completes.
        if (eq) begin
          w_next = S_DONE;
        end else if (r_iter == LP_MAX) begin
          w_next = S_ERR;
        end else if (gt) begin
          ldA        = 1'b1;
          sel1       = 1'b1;
          w_iter_inc = 1'b1;
        end else if (lt) begin
          ldB        = 1'b1;
          sel2       = 1'b1;
          w_iter_inc = 1'b1;
        end else begin
          w_next = S_ERR;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD_A;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_next = S_LOAD_A;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign iter_count = r_iter;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: closes the loop through a behavioural datapath and checks each
// run against a Euclid-based reference model via a scoreboard queue.
module tb_gcd_controller;

  localparam int ITER_W   = 16;
  localparam int MAX_ITER = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              gt, lt, eq;
  logic              ldA, ldB, sel1, sel2, sel_in;
  logic              busy, done, error;
  logic [ITER_W-1:0] iter_count;
  logic [15:0]       data_in = '0;
  logic [15:0]       dp_a = '0;
  logic [15:0]       dp_b = '0;
  logic [15:0]       w_x, w_y, w_bus;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit err;
    int g;
    int cnt;
    int na;
    int nb;
  } exp_t;
  exp_t sb[$];

  gcd_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .gt(gt), .lt(lt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2),
    .sel_in(sel_in), .busy(busy), .done(done), .error(error), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: X=sel1?A:B, Y=sel2?A:B, Bus=sel_in?data_in:(X-Y).
  assign w_x   = sel1 ? dp_a : dp_b;
  assign w_y   = sel2 ? dp_a : dp_b;
  assign w_bus = sel_in ? data_in : (w_x - w_y);
  assign gt    = dp_a > dp_b;
  assign lt    = dp_a < dp_b;
  assign eq    = dp_a == dp_b;
  always @(posedge clk) begin
    if (ldA) dp_a <= w_bus;
    if (ldB) dp_b <= w_bus;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Euclid with quotients: each quotient step on the larger side is that many subtractions.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int x, y, q, r;
    e.err = 0; e.g = 0; e.na = 0; e.nb = 0;
    x = a; y = b;
    if (x == 0 || y == 0) begin
      if (x != y) begin
        e.err = 1;
        e.na  = (x > y) ? MAX_ITER + 1 : 0;
        e.nb  = (y > x) ? MAX_ITER + 1 : 0;
      end
    end else begin
      forever begin
        if (x >= y) begin
          q = x / y; r = x % y;
          if (r == 0) begin e.na += q - 1; e.g = y; break; end
          e.na += q; x = r;
        end else begin
          q = y / x; r = y % x;
          if (r == 0) begin e.nb += q - 1; e.g = x; break; end
          e.nb += q; y = r;
        end
      end
    end
    e.cnt = e.na + e.nb;
    if (e.cnt > MAX_ITER) begin
      e.err = 1;
      e.cnt = MAX_ITER;
    end
    return e;
  endfunction

  // Monitor: counts CALC load pulses and checks each completed run against the scoreboard.
  int  cnt_a = 0, cnt_b = 0;
  bit  armed = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      armed = 0;
    end else begin
      if (ldB && sel_in) begin
        cnt_a = 0; cnt_b = 0; armed = 1;
      end else if (ldA && !sel_in) begin
        cnt_a++;
      end else if (ldB && !sel_in) begin
        cnt_b++;
      end
      if (armed && (done || error)) begin
        armed = 0;
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("error_flag", int'(error), int'(e.err));
          chk("done_flag", int'(done), int'(!e.err));
          chk("iter_count", int'(iter_count), e.cnt);
          if (e.err) begin
            chk("sub_pulses", cnt_a + cnt_b, e.cnt);
          end else begin
            chk("result_A", int'(dp_a), e.g);
            chk("ldA_pulses", cnt_a, e.na);
            chk("ldB_pulses", cnt_b, e.nb);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts a run and loads both operands; optionally stalls in LOAD_A.
  task automatic launch(input int a, input int b, input int stall, input bit push);
    if (push) sb.push_back(model(a, b));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    in_valid = 1'b1;
    data_in  = 16'(a);
    tick();
    data_in  = 16'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int a, b;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_iter", int'(iter_count), 0);
    chk("rst_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    // 48,18 then done holds until the next start
    launch(48, 18, 0, 1);
    wait_end();
    repeat (3) tick();
    chk("done_hold", int'(done), 1);
    chk("done_hold_iter", int'(iter_count), 4);
    chk("done_hold_A", int'(dp_a), 6);

    launch(7, 7, 0, 1);
    wait_end();

    launch(0, 5, 0, 1);
    wait_end();

    // LOAD_A stall: ready with no load until in_valid
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", int'(in_ready), 1);
      chk("stall_ldA", int'(ldA), 0);
      tick();
    end
    sb.push_back(model(13, 1));
    in_valid = 1'b1;
    data_in  = 16'd13;
    #1;
    chk("first_ldA", int'(ldA), 1);
    chk("first_sel_in", int'(sel_in), 1);
    tick();
    data_in = 16'd1;
    tick();
    in_valid = 1'b0;
    // start mid-CALC is ignored
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end();

    // reset mid-CALC
    launch(13, 1, 0, 0);
    repeat (3) tick();
    chk("pre_rst_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ldA", int'(ldA), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_iter", int'(iter_count), 0);
    chk("arst_done_err", int'(done | error), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100));
      launch(a, b, int'($urandom_range(0, 2)), 1);
      wait_end();
    end

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
